// File: rtl/phi_rho_scaler_pkg.sv
// Shared data types and default sizes for the phi*rho scaling datapath.
// phi samples are Q6.10 and rho is Q1.7. The product therefore carries
// 17 fractional bits. Shifting it right by PHI_RHO_SHIFT brings it back
// to the phi scale.
package phi_rho_scaler_pkg;

  localparam int PRS_NCH       = 2;
  localparam int PRS_PHI_W     = 16;
  localparam int PRS_RHO_W     = 8;
  localparam int PHI_RHO_SHIFT = 7;
  localparam int PRS_OUT_W     = 16;
  localparam int PRS_LAT       = 2;

  typedef logic signed [PRS_PHI_W-1:0] phi_t;
  typedef logic signed [PRS_RHO_W-1:0] rho_t;
  typedef phi_t [PRS_NCH-1:0]          phi_vec_t;

endpackage

// File: rtl/phi_rho_scaler_if.sv
// Valid/ready stream bundle for the phi*rho scaler.
// The slave modport is the scaler's view of the bundle. The master modport
// is the environment's view: the upstream producer and the downstream consumer.
interface phi_rho_scaler_if
  import phi_rho_scaler_pkg::*;
#(
  parameter int NCH   = PRS_NCH,
  parameter int PHI_W = PRS_PHI_W,
  parameter int RHO_W = PRS_RHO_W,
  parameter int OUT_W = PRS_OUT_W
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [NCH*PHI_W-1:0]   phi_in;
  logic [RHO_W-1:0]       rho_in;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*OUT_W-1:0]   phi_rho;
  logic                   out_last;
  logic [NCH-1:0]         ovf;

  modport slave (
    input  in_valid, phi_in, rho_in, in_last, out_ready,
    output in_ready, out_valid, phi_rho, out_last, ovf
  );

  modport master (
    output in_valid, phi_in, rho_in, in_last, out_ready,
    input  in_ready, out_valid, phi_rho, out_last, ovf
  );

endinterface

// File: rtl/phi_rho_scaler_lane.sv
// One channel of the phi*rho scaler. This is purely combinational logic.
// The multiply (phi, rho -> prod) and the round/shift/narrow step
// (prod_in -> res, ovf) have separate ports. This lets the top place a
// pipeline register between them.
// Build option PHI_RHO_SAT_EN: when defined, an overflowing result clamps to
// the OUT_W limit with the sign of the product. Otherwise it wraps to the
// low OUT_W bits. ovf is the same in both builds.
module phi_rho_lane
  import phi_rho_scaler_pkg::*;
#(
  parameter int PHI_W = PRS_PHI_W,
  parameter int RHO_W = PRS_RHO_W,
  parameter int SHIFT = PHI_RHO_SHIFT,
  parameter int OUT_W = PRS_OUT_W,
  parameter int ROUND = 0
) (
  input  logic signed [PHI_W-1:0]       phi,
  input  logic signed [RHO_W-1:0]       rho,
  output logic signed [PHI_W+RHO_W-1:0] prod,
  input  logic signed [PHI_W+RHO_W-1:0] prod_in,
  output logic signed [OUT_W-1:0]       res,
  output logic                          ovf
);

  localparam int PROD_W = PHI_W + RHO_W;
  localparam int EXT_W  = PROD_W + 1;
  localparam logic [EXT_W-1:0] BIAS =
    (ROUND != 0) ? (EXT_W'(1) << (SHIFT - 1)) : EXT_W'(0);

  logic signed [PROD_W-1:0] phi_x;
  logic signed [PROD_W-1:0] rho_x;
  logic signed [EXT_W-1:0]  ext;
  logic signed [EXT_W-1:0]  shifted;
  logic [EXT_W-OUT_W:0]     upper;

  // Sign-extend both operands to the full product width before multiplying.
  always_comb begin
    phi_x = {{RHO_W{phi[PHI_W-1]}}, phi};
    rho_x = {{PHI_W{rho[RHO_W-1]}}, rho};
    prod  = phi_x * rho_x;
  end

  // Add one extra headroom bit so the rounding bias cannot wrap, then shift arithmetically.
  always_comb begin
    ext     = {prod_in[PROD_W-1], prod_in} + BIAS;
    shifted = ext >>> SHIFT;
    upper   = shifted[EXT_W-1:OUT_W-1];
    ovf     = !((&upper) || !(|upper));
  end

`ifdef PHI_RHO_SAT_EN
  // Clamp on overflow toward the sign of the product.
  always_comb begin
    res = shifted[OUT_W-1:0];
    if (ovf) begin
      res = prod_in[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  // Wrap: keep the low OUT_W bits of the shifted value.
  always_comb begin
    res = shifted[OUT_W-1:0];
  end
`endif

endmodule

// File: rtl/phi_rho_scaler.sv
// Multi-channel phi*rho scaler. NCH phi samples share one rho on each beat.
// The pipeline has LAT register stages, each holding {valid, last, payload}.
// Stage 0 captures the raw products. The last stage captures the narrowed
// results and the ovf flags. Any stage in between carries the products forward.
// Bubbles collapse: a stage loads when it, or some stage downstream of it,
// is empty, or when the consumer takes the output beat.
// With a free-running consumer, a beat accepted at edge n is handed
// downstream at edge n+LAT.
// Build option PHI_RHO_SAT_EN selects saturating narrowing (see phi_rho_lane).
module phi_rho_scaler
  import phi_rho_scaler_pkg::*;
#(
  parameter int NCH   = PRS_NCH,
  parameter int PHI_W = PRS_PHI_W,
  parameter int RHO_W = PRS_RHO_W,
  parameter int SHIFT = PHI_RHO_SHIFT,
  parameter int OUT_W = PRS_OUT_W,
  parameter int LAT   = PRS_LAT,
  parameter int ROUND = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  phi_rho_scaler_if.slave   bus
);

  localparam int PROD_W = PHI_W + RHO_W;

  logic [LAT-1:0]            stg_valid;
  logic [LAT-1:0]            stg_last;
  logic [LAT-1:0]            stg_load;
  logic                      fin_en;
  logic signed [PROD_W-1:0]  prod_comb [NCH];
  logic signed [PROD_W-1:0]  narrow_in [NCH];
  logic [NCH*OUT_W-1:0]      res_comb;
  logic [NCH-1:0]            ovf_comb;
  logic [NCH*OUT_W-1:0]      res_q;
  logic [NCH-1:0]            ovf_q;

  // A stage may load when any stage from it to the tail is empty, or when the consumer takes the tail.
  for (genvar k = 0; k < LAT; k++) begin : g_load
    assign stg_load[k] = !(&stg_valid[LAT-1:k]) || bus.out_ready;
  end

  // One lane per channel. Multiply from the input bus; narrow from the stage feeding the tail.
  for (genvar c = 0; c < NCH; c++) begin : g_lane
    phi_rho_lane #(
      .PHI_W (PHI_W),
      .RHO_W (RHO_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W),
      .ROUND (ROUND)
    ) u_lane (
      .phi     (bus.phi_in[c*PHI_W +: PHI_W]),
      .rho     (bus.rho_in),
      .prod    (prod_comb[c]),
      .prod_in (narrow_in[c]),
      .res     (res_comb[c*OUT_W +: OUT_W]),
      .ovf     (ovf_comb[c])
    );
  end

  if (LAT == 1) begin : g_lat1
    // A single stage does the multiply and the narrowing in the same cycle.
    assign fin_en    = stg_load[0] && bus.in_valid;
    assign narrow_in = prod_comb;
  end else begin : g_latn
    logic signed [PROD_W-1:0] prod_q [LAT-1][NCH];

    // Product registers for stages 0..LAT-2. A stage holds its value unless a real beat moves in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < LAT - 1; k++) begin
          for (int c = 0; c < NCH; c++) begin
            prod_q[k][c] <= '0;
          end
        end
      end else begin
        if (stg_load[0] && bus.in_valid) begin
          prod_q[0] <= prod_comb;
        end
        for (int k = 1; k < LAT - 1; k++) begin
          if (stg_load[k] && stg_valid[k-1]) begin
            prod_q[k] <= prod_q[k-1];
          end
        end
      end
    end

    assign fin_en    = stg_load[LAT-1] && stg_valid[LAT-2];
    assign narrow_in = prod_q[LAT-2];
  end

  // Valid and last travel through every stage. Last changes only when a real beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      stg_last  <= '0;
    end else begin
      if (stg_load[0]) begin
        stg_valid[0] <= bus.in_valid;
        if (bus.in_valid) begin
          stg_last[0] <= bus.in_last;
        end
      end
      for (int k = 1; k < LAT; k++) begin
        if (stg_load[k]) begin
          stg_valid[k] <= stg_valid[k-1];
          if (stg_valid[k-1]) begin
            stg_last[k] <= stg_last[k-1];
          end
        end
      end
    end
  end

  // The tail payload holds the narrowed results and is frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      ovf_q <= '0;
    end else if (fin_en) begin
      res_q <= res_comb;
      ovf_q <= ovf_comb;
    end
  end

  assign bus.in_ready  = stg_load[0];
  assign bus.out_valid = stg_valid[LAT-1];
  assign bus.out_last  = stg_last[LAT-1];
  assign bus.phi_rho   = res_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_phi_rho_scaler.sv
// Bench for phi_rho_scaler. It runs a truncating instance and a rounding
// instance side by side. Directed table vectors use hand-computed results.
// Hand-written sequences cover backpressure, bubble collapse and a reset in
// the middle of a stream.
// Overflow expectations follow the PHI_RHO_SAT_EN build option.
module tb_phi_rho_scaler;
  import phi_rho_scaler_pkg::*;

  localparam int LAT = PRS_LAT;

`ifdef PHI_RHO_SAT_EN
  localparam int OVF_POS = 32767;
`else
  localparam int OVF_POS = -32768;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  phi_rho_scaler_if bus_t ();
  phi_rho_scaler_if bus_r ();

  phi_rho_scaler #(.ROUND(0)) dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t.slave));
  phi_rho_scaler #(.ROUND(1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r.slave));

  typedef struct {
    logic signed [15:0] phi0;
    logic signed [15:0] phi1;
    logic signed [7:0]  rho;
    logic               last;
    logic signed [15:0] tr0;
    logic signed [15:0] tr1;
    logic signed [15:0] rd0;
    logic signed [15:0] rd1;
    logic [1:0]         ovf;
  } vec_t;

  typedef struct {
    logic signed [15:0] r0;
    logic signed [15:0] r1;
    logic               last;
  } beat_t;

  vec_t  vecs [9];
  beat_t sb [$];
  int    vec_count    = 0;
  int    miss_count   = 0;
  int    emit_total   = 0;
  logic  last_accept  = 1'b0;
  logic  stalled_prev = 1'b0;

  // Watchdog so the run always ends, even if the sequences never complete.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkv(input int p0, input int p1, input int r, input bit l,
                               input int t0, input int t1, input int r0, input int r1,
                               input logic [1:0] o);
    vec_t v;
    v.phi0 = 16'(p0); v.phi1 = 16'(p1); v.rho = 8'(r); v.last = l;
    v.tr0  = 16'(t0); v.tr1  = 16'(t1); v.rd0 = 16'(r0); v.rd1 = 16'(r1);
    v.ovf  = o;
    return v;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int p0, input int p1, input int r,
                               input logic l, input logic ordy);
    phi_vec_t pv;
    pv[0] = 16'(p0);
    pv[1] = 16'(p1);
    bus_t.in_valid = v;  bus_t.phi_in = pv; bus_t.rho_in = 8'(r);
    bus_t.in_last  = l;  bus_t.out_ready = ordy;
    bus_r.in_valid = v;  bus_r.phi_in = pv; bus_r.rho_in = 8'(r);
    bus_r.in_last  = l;  bus_r.out_ready = ordy;
  endtask

  // Scoreboard check of the truncating instance, sampled mid-cycle.
  task automatic checkOutput(input logic ordy);
    checkVal("in_ready", int'(bus_t.in_ready), int'(!(sb.size() == LAT && !ordy)));
    if (stalled_prev) checkVal("hold_valid", int'(bus_t.out_valid), 1);
    if (bus_t.out_valid) begin
      checkVal("beat_pending", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        checkVal("sb_res0", int'($signed(bus_t.phi_rho[15:0])),  int'(sb[0].r0));
        checkVal("sb_res1", int'($signed(bus_t.phi_rho[31:16])), int'(sb[0].r1));
        checkVal("sb_last", int'(bus_t.out_last), int'(sb[0].last));
        checkVal("sb_ovf",  int'(bus_t.ovf), 0);
      end
    end
  endtask

  // One clock of streaming traffic with the scoreboard model kept up to date.
  task automatic cycle(input logic v, input int p0, input int p1, input int r,
                       input logic l, input logic ordy, input int e0, input int e1);
    beat_t b;
    @(negedge clk);
    applyStimulus(v, p0, p1, r, l, ordy);
    #1;
    checkOutput(ordy);
    last_accept = v && bus_t.in_ready;
    if (bus_t.out_valid && ordy) begin
      if (sb.size() != 0) void'(sb.pop_front());
      emit_total++;
    end
    if (last_accept) begin
      b.r0 = 16'(e0); b.r1 = 16'(e1); b.last = l;
      sb.push_back(b);
    end
    stalled_prev = bus_t.out_valid && !ordy;
    @(posedge clk);
  endtask

  initial begin
    int i;
    int t;
    int e0;

    vecs[0] = mkv(1024, -1024, 64, 1'b0, 512, -512, 512, -512, 2'b00);
    vecs[1] = mkv(3, -3, 22, 1'b0, 0, -1, 1, -1, 2'b00);
    vecs[2] = mkv(3, 0, 21, 1'b1, 0, 0, 0, 0, 2'b00);
    vecs[3] = mkv(-32768, 100, -128, 1'b0, OVF_POS, -100, OVF_POS, -100, 2'b01);
    vecs[4] = mkv(32767, -32768, 127, 1'b1, 32511, -32512, 32511, -32512, 2'b00);
    vecs[5] = mkv(-1, 1, 1, 1'b0, -1, 0, 0, 0, 2'b00);
    vecs[6] = mkv(-32768, -32768, 127, 1'b0, -32512, -32512, -32512, -32512, 2'b00);
    vecs[7] = mkv(16384, -16384, -128, 1'b1, -16384, 16384, -16384, 16384, 2'b00);
    vecs[8] = mkv(-32768, 32767, -128, 1'b0, OVF_POS, -32767, OVF_POS, -32767, 2'b01);

    // Reset state.
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    #12;
    checkVal("rst_out_valid", int'(bus_t.out_valid), 0);
    checkVal("rst_out_last",  int'(bus_t.out_last), 0);
    checkVal("rst_ovf",       int'(bus_t.ovf), 0);
    checkVal("rst_phi_rho",   int'(bus_t.phi_rho), 0);
    checkVal("rst_out_valid_r", int'(bus_r.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkVal("rst_in_ready", int'(bus_t.in_ready), 1);

    // Table vectors: one beat each, with latency and result checked on both instances.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[k].phi0, vecs[k].phi1, vecs[k].rho, vecs[k].last, 1'b1);
      #1;
      checkVal($sformatf("v%0d_in_ready", k), int'(bus_t.in_ready), 1);
      @(posedge clk);
      for (int s = 0; s < LAT; s++) begin
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        if (s < LAT - 1) begin
          checkVal($sformatf("v%0d_early_valid", k), int'(bus_t.out_valid), 0);
        end else begin
          checkVal($sformatf("v%0d_valid_t", k), int'(bus_t.out_valid), 1);
          checkVal($sformatf("v%0d_res0_t", k), int'($signed(bus_t.phi_rho[15:0])),  int'(vecs[k].tr0));
          checkVal($sformatf("v%0d_res1_t", k), int'($signed(bus_t.phi_rho[31:16])), int'(vecs[k].tr1));
          checkVal($sformatf("v%0d_ovf_t", k),  int'(bus_t.ovf), int'(vecs[k].ovf));
          checkVal($sformatf("v%0d_last_t", k), int'(bus_t.out_last), int'(vecs[k].last));
          checkVal($sformatf("v%0d_valid_r", k), int'(bus_r.out_valid), 1);
          checkVal($sformatf("v%0d_res0_r", k), int'($signed(bus_r.phi_rho[15:0])),  int'(vecs[k].rd0));
          checkVal($sformatf("v%0d_res1_r", k), int'($signed(bus_r.phi_rho[31:16])), int'(vecs[k].rd1));
          checkVal($sformatf("v%0d_ovf_r", k),  int'(bus_r.ovf), int'(vecs[k].ovf));
        end
      end
    end
    @(negedge clk);
    #1;
    checkVal("table_drained", int'(bus_t.out_valid), 0);

    // Backpressure: 8 beats with out_ready cycling 1,0,0,1.
    $display("[TB] backpressure stream");
    e0 = emit_total;
    i  = 0;
    t  = 0;
    while (i < 8 && t < 200) begin
      cycle(1'b1, 256 * (i + 1), -128 * (i + 1), 64, (i == 7),
            ((t % 4) == 0) || ((t % 4) == 3), 128 * (i + 1), -64 * (i + 1));
      if (last_accept) i++;
      t++;
    end
    checkVal("bp_accepted", i, 8);
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
      t++;
    end
    checkVal("bp_emitted", emit_total - e0, 8);
    checkVal("bp_sb_empty", sb.size(), 0);

    // Bubble collapse: stage 0 keeps accepting into an empty slot, then refuses when the pipeline is full.
    $display("[TB] bubble collapse");
    cycle(1'b1, 256, -128, 64, 1'b0, 1'b1, 128, -64);
    cycle(1'b1, 512, -256, 64, 1'b1, 1'b0, 256, -128);
    checkVal("bubble_second_accept", int'(last_accept), 1);
    cycle(1'b1, 768, -384, 64, 1'b0, 1'b0, 384, -192);
    checkVal("bubble_full_refuse", int'(last_accept), 0);
    cycle(1'b1, 768, -384, 64, 1'b0, 1'b0, 384, -192);
    checkVal("bubble_held", sb.size(), 2);
    e0 = emit_total;
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
    checkVal("bubble_back_to_back", emit_total - e0, 2);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);

    // Reset mid-stream with two beats in flight.
    $display("[TB] reset mid-stream");
    cycle(1'b1, 1024, 1024, 64, 1'b0, 1'b1, 512, 512);
    cycle(1'b1, 2048, 2048, 64, 1'b1, 1'b1, 1024, 1024);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    #1;
    checkVal("pre_rst_valid", int'(bus_t.out_valid), 1);
    rst_n = 1'b0;
    #1;
    checkVal("async_rst_valid_t", int'(bus_t.out_valid), 0);
    checkVal("async_rst_valid_r", int'(bus_r.out_valid), 0);
    checkVal("async_rst_phi_rho", int'(bus_t.phi_rho), 0);
    checkVal("async_rst_last",    int'(bus_t.out_last), 0);
    sb.delete();
    stalled_prev = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = emit_total;
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
    checkVal("no_stale_beat", emit_total - e0, 0);
    cycle(1'b1, 512, -512, 64, 1'b1, 1'b1, 256, -256);
    checkVal("post_rst_accept", int'(last_accept), 1);
    for (int s = 0; s < LAT - 1; s++) begin
      @(negedge clk);
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
      #1;
      checkVal("post_rst_early", int'(bus_t.out_valid), 0);
      @(posedge clk);
    end
    e0 = emit_total;
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
    checkVal("post_rst_latency", emit_total - e0, 1);
    checkVal("post_rst_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
